stopwatch_counter: RTL and testbench
====================================

Name: stopwatch_counter

Overview:
Consumer of the divider's output clocks: turns the 1 Hz, 2 Hz and blink levels into single-cycle tick enables and keeps the stopwatch time as BCD minutes:seconds.
- Supports run/pause, an adjust mode that advances one selected field at 2 Hz, and blink-blanking of the selected field while adjusting.
- Outputs feed the seven-segment multiplexer, which runs on the fast divided clock.
- Everything runs on the single master clock; divided clocks are data, never clocks.

Parameters:
MAX_MIN, 99, highest minute value before the minute field wraps to 0; legal 1..99.
SEC_WRAP, 59, highest second value before the seconds field wraps to 0; legal 1..59.

Ports:
clk  input  1  100 MHz master clock
rst  input  1  asynchronous, active-high reset
onehz_clk  input  1  1 Hz square wave from the divider, synchronous to clk
twohz_clk  input  1  2 Hz square wave from the divider, synchronous to clk
blink_clk  input  1  blink square wave from the divider, synchronous to clk
pause_btn  input  1  debounced level; each rising edge toggles run/pause
adj  input  1  level; 1 = adjust mode
sel  input  1  adjust field select: 0 = minutes, 1 = seconds
min_tens  output  4  BCD minutes tens digit
min_ones  output  4  BCD minutes ones digit
sec_tens  output  4  BCD seconds tens digit
sec_ones  output  4  BCD seconds ones digit
digit_blank  output  4  per-digit blank, order {min_tens,min_ones,sec_tens,sec_ones}; 1 = blank
running  output  1  1 when in state RUN

Behaviour:
- Reset (asynchronous, active-high):
  - all digits 0, digit_blank=0, running=0, state PAUSED.
  - Edge-history registers for onehz, twohz and pause cleared to 0.
- Edge detection:
  - a registered previous value is kept per input.
  - tick1 = onehz_clk & ~prev1; tick2 = twohz_clk & ~prev2; pedge = pause_btn & ~prevp.
  - Each pulse lasts exactly one cycle per rising edge.
  - A counter update occurs on the same clk edge at which the pulse is high, so the output changes 1 cycle after the input rises.
  - An input held high produces no further ticks.
- State machine (PAUSED, RUN):
  - PAUSED -> RUN on pedge; RUN -> PAUSED on pedge.
  - pedge is ignored while adj=1; the state is held.
- Normal counting (adj=0, state RUN) on tick1:
  - seconds +1; at SEC_WRAP, seconds -> 00 and minutes +1.
  - At minutes=MAX_MIN and seconds=SEC_WRAP, both fields -> 00.
  - No overflow flag.
- Simultaneous pedge and tick1:
  - the tick is honoured only if the pre-edge state is RUN.
  - RUN->PAUSED with tick: the increment happens.
  - PAUSED->RUN with tick: no increment.
- Adjust mode (adj=1):
  - tick1 is ignored; on tick2 the selected field increments regardless of run/pause state.
  - sel=1: seconds +1, wrapping SEC_WRAP->00 with no carry into minutes.
  - sel=0: minutes +1, wrapping MAX_MIN->00.
  - sel changes take effect on the next tick2.
- Blanking:
  - digit_blank is registered: 1-cycle latency from adj/sel/blink_clk.
  - When adj=1 and blink_clk=0, the two selected digits are blanked; otherwise digit_blank=0.
  - Leaving adjust mode clears blanking on the next cycle; run/pause state is unchanged.
- Arithmetic:
  - BCD per digit: ones 9 -> 0 with carry into tens.
  - The wrap compare uses the full two-digit BCD value against the parameter converted to BCD.
  - Illegal BCD never appears on the outputs.
- Reset mid-count: the asynchronous reset forces all reset values immediately, independent of clk.

Optional Feature:
LAP_HOLD_EN
- Defined:
  - adds input port lap_btn (1 bit, debounced level) and a 16-bit display hold register.
  - A lap_btn rising edge toggles hold. While holding, the digit outputs show the value captured at the toggle-on edge, while internal counting continues.
  - Toggle-off shows live time on the next cycle.
  - Hold is cleared by reset and by entering adjust mode.
- Not defined: no lap_btn port; digit outputs always show live time.

Test Plan:
- Reset, then pedge, then 3 tick1 pulses -> running=1; digits 00:03, each changing 1 cycle after its onehz rising edge.
- Preload 00:59 via adjust, run, one tick1 -> 01:00; preload 99:59, one tick1 -> 00:00.
- adj=1, sel=1 at 00:58, 3 tick2 pulses -> 00:01 with minutes unchanged; tick1 pulses meanwhile produce no change.
- adj=1, sel=0, blink_clk low -> digit_blank=4'b1100 after 1 cycle; blink_clk high -> 4'b0000; sel=1, blink_clk low -> 4'b0011.
- pedge and tick1 in the same cycle in RUN at 00:10 -> 00:11 and running=0; the same in PAUSED at 00:10 -> 00:10 and running=1.
- Assert rst asynchronously mid-count at 12:34 -> all digits 0, running=0 before the next clk edge. With LAP_HOLD_EN: hold at 00:05, 3 tick1 -> display 00:05; release -> 00:08.

Source files
------------

// File: rtl/stopwatch_counter_if.sv
// stopwatch_counter_if
//   Bundles the stopwatch control inputs (divider levels, buttons, adjust
//   controls) and the BCD display outputs into one port.
//
//   Modports:
//     master : the side that drives the divider levels and buttons and reads
//              the display (divider/button logic, or a testbench).
//     slave  : the stopwatch counter itself.
//
//   Optional: when LAP_HOLD_EN is defined, the interface also carries lap_btn.
interface stopwatch_counter_if;
  logic       onehz_clk;    // 1 Hz square wave, synchronous to clk
  logic       twohz_clk;    // 2 Hz square wave, synchronous to clk
  logic       blink_clk;    // blink square wave, synchronous to clk
  logic       pause_btn;    // debounced level, rising edge toggles run/pause
  logic       adj;          // 1 = adjust mode
  logic       sel;          // adjust field: 0 = minutes, 1 = seconds
`ifdef LAP_HOLD_EN
  logic       lap_btn;      // debounced level, rising edge toggles display hold
`endif
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] digit_blank;  // {min_tens, min_ones, sec_tens, sec_ones}, 1 = blank
  logic       running;

`ifdef LAP_HOLD_EN
  modport master (
    output onehz_clk, twohz_clk, blink_clk, pause_btn, adj, sel, lap_btn,
    input  min_tens, min_ones, sec_tens, sec_ones, digit_blank, running
  );

  modport slave (
    input  onehz_clk, twohz_clk, blink_clk, pause_btn, adj, sel, lap_btn,
    output min_tens, min_ones, sec_tens, sec_ones, digit_blank, running
  );
`else
  modport master (
    output onehz_clk, twohz_clk, blink_clk, pause_btn, adj, sel,
    input  min_tens, min_ones, sec_tens, sec_ones, digit_blank, running
  );

  modport slave (
    input  onehz_clk, twohz_clk, blink_clk, pause_btn, adj, sel,
    output min_tens, min_ones, sec_tens, sec_ones, digit_blank, running
  );
`endif
endinterface

// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   Turns the divider's 1 Hz / 2 Hz / blink levels into single-cycle enables
//   and keeps the stopwatch time as BCD minutes:seconds. Supports run/pause,
//   an adjust mode that advances the selected field on each 2 Hz edge, and
//   blink-blanking of the selected field while adjusting. All logic runs on
//   clk; the divided "clocks" are sampled as data.
//
//   Ports:
//     clk  : master clock
//     rst  : asynchronous, active-high reset
//     sw   : stopwatch_counter_if.slave
//            in : onehz_clk, twohz_clk, blink_clk, pause_btn, adj, sel
//                 (+ lap_btn with LAP_HOLD_EN)
//            out: min_tens, min_ones, sec_tens, sec_ones, digit_blank, running
//
//   Parameters:
//     MAX_MIN  : last minute value before minutes wrap to 0 (1..99)
//     SEC_WRAP : last second value before seconds wrap to 0 (1..59)
//
//   Optional feature macro: LAP_HOLD_EN
//     Adds a lap_btn input; each rising edge toggles a display hold that
//     freezes the digit outputs while counting continues. Hold is cleared by
//     reset and while adjust mode is active.
module stopwatch_counter #(
  parameter int unsigned MAX_MIN  = 99,
  parameter int unsigned SEC_WRAP = 59
) (
  input logic          clk,
  input logic          rst,
  stopwatch_counter_if.slave sw
);

  // Wrap limits as two-digit BCD so they compare directly against the fields.
  localparam logic [7:0] MinLim = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0] SecLim = {4'(SEC_WRAP / 10), 4'(SEC_WRAP % 10)};

  localparam logic [0:0] StPaused = 1'b0;
  localparam logic [0:0] StRun    = 1'b1;

  // Two-digit BCD increment with wrap to 00 at the limit. For legal BCD the
  // packed compare is a numeric compare, so ">=" also recovers any value
  // above the limit instead of counting on into illegal codes.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] lim);
    logic [7:0] res;
    if (val >= lim) begin
      res = 8'h00;
    end else if (val[3:0] >= 4'd9) begin
      res = {val[7:4] + 4'd1, 4'd0};
    end else begin
      res = {val[7:4], val[3:0] + 4'd1};
    end
    return res;
  endfunction

  // Edge history
  logic prev1_q, prev2_q, prevp_q;
  logic tick1, tick2, pedge;

  // State and time
  logic [0:0] state_q, state_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic [3:0] blank_q, blank_d;

  // Value driven onto the digit outputs
  logic [15:0] disp;

  assign tick1 = sw.onehz_clk & ~prev1_q;
  assign tick2 = sw.twohz_clk & ~prev2_q;
  assign pedge = sw.pause_btn & ~prevp_q;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;

    // Buttons are locked out while adjusting so the run state survives it.
    if (pedge && !sw.adj) begin
      state_d = (state_q == StRun) ? StPaused : StRun;
    end

    if (sw.adj) begin
      if (tick2) begin
        if (sw.sel) begin
          sec_d = bcd_inc(sec_q, SecLim);  // no carry into minutes
        end else begin
          min_d = bcd_inc(min_q, MinLim);
        end
      end
    end else if (tick1 && (state_q == StRun)) begin
      // Gated on the pre-edge state: a tick coinciding with pause still
      // counts, one coinciding with resume does not.
      if (sec_q >= SecLim) begin
        sec_d = 8'h00;
        min_d = bcd_inc(min_q, MinLim);
      end else begin
        sec_d = bcd_inc(sec_q, SecLim);
      end
    end
  end

  always_comb begin
    blank_d = 4'b0000;
    if (sw.adj && !sw.blink_clk) begin
      blank_d = sw.sel ? 4'b0011 : 4'b1100;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev1_q <= 1'b0;
      prev2_q <= 1'b0;
      prevp_q <= 1'b0;
      state_q <= StPaused;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      blank_q <= 4'b0000;
    end else begin
      prev1_q <= sw.onehz_clk;
      prev2_q <= sw.twohz_clk;
      prevp_q <= sw.pause_btn;
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      blank_q <= blank_d;
    end
  end

`ifdef LAP_HOLD_EN
  logic        prevl_q;
  logic        ledge;
  logic        hold_q, hold_d;
  logic [15:0] hold_val_q, hold_val_d;

  assign ledge = sw.lap_btn & ~prevl_q;

  always_comb begin
    hold_d     = hold_q;
    hold_val_d = hold_val_q;
    if (sw.adj) begin
      hold_d = 1'b0;
    end else if (ledge) begin
      hold_d = ~hold_q;
      // Capture the time shown at the moment the hold is switched on.
      if (!hold_q) begin
        hold_val_d = {min_q, sec_q};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prevl_q    <= 1'b0;
      hold_q     <= 1'b0;
      hold_val_q <= 16'h0000;
    end else begin
      prevl_q    <= sw.lap_btn;
      hold_q     <= hold_d;
      hold_val_q <= hold_val_d;
    end
  end

  assign disp = hold_q ? hold_val_q : {min_q, sec_q};
`else
  assign disp = {min_q, sec_q};
`endif

  assign sw.min_tens    = disp[15:12];
  assign sw.min_ones    = disp[11:8];
  assign sw.sec_tens    = disp[7:4];
  assign sw.sec_ones    = disp[3:0];
  assign sw.digit_blank = blank_q;
  assign sw.running     = (state_q == StRun);

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  stopwatch_counter_if sw_if();

  stopwatch_counter #(
    .MAX_MIN (99),
    .SEC_WRAP(59)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [15:0] disp = {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    step();
  endtask

  task automatic pulse_1hz();
    sw_if.onehz_clk = 1'b1;
    step();
    sw_if.onehz_clk = 1'b0;
    step();
  endtask

  task automatic pulse_2hz();
    sw_if.twohz_clk = 1'b1;
    step();
    sw_if.twohz_clk = 1'b0;
    step();
  endtask

  task automatic press_pause();
    sw_if.pause_btn = 1'b1;
    step();
    sw_if.pause_btn = 1'b0;
    step();
  endtask

  // Reset, then load mm:ss through adjust mode; leaves the watch paused.
  task automatic set_time(input int mm, input int ss);
    do_reset();
    sw_if.adj = 1'b1;
    sw_if.sel = 1'b0;
    for (int i = 0; i < mm; i++) pulse_2hz();
    sw_if.sel = 1'b1;
    for (int i = 0; i < ss; i++) pulse_2hz();
    sw_if.adj = 1'b0;
    step();
  endtask

  initial begin
    n_checks        = 0;
    n_pass          = 0;
    rst             = 1'b0;
    sw_if.onehz_clk = 1'b0;
    sw_if.twohz_clk = 1'b0;
    sw_if.blink_clk = 1'b1;
    sw_if.pause_btn = 1'b0;
    sw_if.adj       = 1'b0;
    sw_if.sel       = 1'b0;
`ifdef LAP_HOLD_EN
    sw_if.lap_btn   = 1'b0;
`endif
    step();
    do_reset();

    // Reset values
    check("reset_disp", 32'(disp), 32'h0000);
    check("reset_blank", 32'(sw_if.digit_blank), 32'h0);
    check("reset_running", 32'(sw_if.running), 32'h0);

    // Start, then three 1 Hz edges; first one held high to check single tick
    press_pause();
    check("run_after_pedge", 32'(sw_if.running), 32'h1);
    sw_if.onehz_clk = 1'b1;
    check("tick1_before_edge", 32'(disp), 32'h0000);
    step();
    check("tick1_latency", 32'(disp), 32'h0001);
    step();
    step();
    check("tick1_held_high", 32'(disp), 32'h0001);
    sw_if.onehz_clk = 1'b0;
    step();
    pulse_1hz();
    pulse_1hz();
    check("count_00_03", 32'(disp), 32'h0003);

    // Carry seconds into minutes, and full wrap
    set_time(0, 59);
    check("preload_00_59", 32'(disp), 32'h0059);
    press_pause();
    pulse_1hz();
    check("carry_01_00", 32'(disp), 32'h0100);
    set_time(99, 59);
    check("preload_99_59", 32'(disp), 32'h9959);
    press_pause();
    pulse_1hz();
    check("wrap_00_00", 32'(disp), 32'h0000);

    // Adjust seconds at 00:58: wraps without carrying, 1 Hz ignored
    set_time(0, 58);
    sw_if.adj = 1'b1;
    sw_if.sel = 1'b1;
    pulse_2hz();
    check("adj_sec_59", 32'(disp), 32'h0059);
    pulse_1hz();
    check("adj_ignores_tick1", 32'(disp), 32'h0059);
    pulse_2hz();
    check("adj_sec_wrap_nocarry", 32'(disp), 32'h0000);
    pulse_2hz();
    check("adj_sec_01", 32'(disp), 32'h0001);

    // Blanking of the selected field, 1-cycle latency
    sw_if.sel       = 1'b0;
    sw_if.blink_clk = 1'b0;
    check("blank_latency", 32'(sw_if.digit_blank), 32'h0);
    step();
    check("blank_min", 32'(sw_if.digit_blank), 32'hC);
    sw_if.blink_clk = 1'b1;
    step();
    check("blank_blink_high", 32'(sw_if.digit_blank), 32'h0);
    sw_if.sel       = 1'b1;
    sw_if.blink_clk = 1'b0;
    step();
    check("blank_sec", 32'(sw_if.digit_blank), 32'h3);
    sw_if.adj = 1'b0;
    step();
    check("blank_clear_on_exit", 32'(sw_if.digit_blank), 32'h0);
    check("exit_adj_keeps_paused", 32'(sw_if.running), 32'h0);
    sw_if.blink_clk = 1'b1;

    // pedge ignored in adjust mode
    sw_if.adj = 1'b1;
    press_pause();
    check("adj_blocks_pedge", 32'(sw_if.running), 32'h0);
    sw_if.adj = 1'b0;
    step();

    // Simultaneous pedge and tick1
    set_time(0, 10);
    press_pause();
    sw_if.onehz_clk = 1'b1;
    sw_if.pause_btn = 1'b1;
    step();
    check("sim_run_disp", 32'(disp), 32'h0011);
    check("sim_run_state", 32'(sw_if.running), 32'h0);
    sw_if.onehz_clk = 1'b0;
    sw_if.pause_btn = 1'b0;
    step();
    set_time(0, 10);
    sw_if.onehz_clk = 1'b1;
    sw_if.pause_btn = 1'b1;
    step();
    check("sim_pause_disp", 32'(disp), 32'h0010);
    check("sim_pause_state", 32'(sw_if.running), 32'h1);
    sw_if.onehz_clk = 1'b0;
    sw_if.pause_btn = 1'b0;
    step();

    // Asynchronous reset between clock edges
    set_time(12, 34);
    press_pause();
    check("preload_12_34", 32'(disp), 32'h1234);
    rst = 1'b1;
    #2;
    check("async_rst_disp", 32'(disp), 32'h0000);
    check("async_rst_running", 32'(sw_if.running), 32'h0);
    rst = 1'b0;
    step();

`ifdef LAP_HOLD_EN
    set_time(0, 5);
    press_pause();
    sw_if.lap_btn = 1'b1;
    step();
    sw_if.lap_btn = 1'b0;
    step();
    pulse_1hz();
    pulse_1hz();
    pulse_1hz();
    check("lap_hold_disp", 32'(disp), 32'h0005);
    sw_if.lap_btn = 1'b1;
    step();
    check("lap_release_live", 32'(disp), 32'h0008);
    sw_if.lap_btn = 1'b0;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
